// File: rtl/risac_mem_model.sv
// rtl/risac_mem_model.sv - risac memory/peripheral slave with wait states and console FIFO
//
// Purpose: separate instruction and data word arrays with programmable wait
// states on both buses, byte/half/word stores and a console TX FIFO mapped at
// CONSOLE_ADDR (not backed by dmem).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   iIbusAddr                fetch byte address
//   oIbusData / oIbusIAddr   fetched word and the address it belongs to
//   oIbusWait                fetched word not valid for iIbusAddr
//   iDbusAddr/We/Read/Data   data request (store data right-aligned)
//   iDbusByteEn              4'h1 byte, 4'h3 half, 4'hF word
//   oDbusData                aligned read word, valid in the completion cycle
//   oDbusWait                current data request not yet complete
//   oConsValid/oConsData     console FIFO head
//   iConsReady               pop the head when valid
module risac_mem_model #(
  parameter int          ADDR_W       = 8,
  parameter int          IWAIT        = 0,
  parameter int          DWAIT        = 0,
  parameter logic [31:0] CONSOLE_ADDR = 32'h0,
  parameter int          CONS_DEPTH   = 16,
  parameter string       IMEM_INIT    = "",
  parameter string       DMEM_INIT    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iIbusAddr,
  output logic [31:0] oIbusData,
  output logic [31:0] oIbusIAddr,
  output logic        oIbusWait,
  input  logic [31:0] iDbusAddr,
  input  logic        iDbusWe,
  input  logic        iDbusRead,
  input  logic [31:0] iDbusData,
  input  logic [3:0]  iDbusByteEn,
  output logic [31:0] oDbusData,
  output logic        oDbusWait,
  output logic        oConsValid,
  output logic [7:0]  oConsData,
  input  logic        iConsReady
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = $clog2(CONS_DEPTH);

  logic [31:0] imem [DEPTH];
  logic [31:0] dmem [DEPTH];

  // ---------------------------------------------------------------- ibus
  typedef enum logic {I_IDLE, I_WAIT} i_state_t;

  i_state_t    i_state;
  logic [3:0]  i_cnt;
  logic [31:0] i_addr;

  assign oIbusWait = (iIbusAddr != oIbusIAddr) | (i_state == I_WAIT);

  // The idle cycle that spots the new address is the first of the 1+IWAIT
  // wait cycles, so the counter starts one below IWAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_state    <= I_IDLE;
      i_cnt      <= 4'd0;
      i_addr     <= 32'd0;
      oIbusData  <= 32'd0;
      oIbusIAddr <= 32'hFFFF_FFFF;
    end else begin
      case (i_state)
        I_IDLE: begin
          if (iIbusAddr != oIbusIAddr) begin
            if (IWAIT == 0) begin
              oIbusData  <= imem[iIbusAddr[ADDR_W+1:2]];
              oIbusIAddr <= iIbusAddr;
            end else begin
              i_addr  <= iIbusAddr;
              i_cnt   <= 4'(IWAIT - 1);
              i_state <= I_WAIT;
            end
          end
        end
        I_WAIT: begin
          // Finish the in-flight fetch even if the core moved on; the
          // address compare in I_IDLE then restarts for the new address.
          if (i_cnt == 4'd0) begin
            oIbusData  <= imem[i_addr[ADDR_W+1:2]];
            oIbusIAddr <= i_addr;
            i_state    <= I_IDLE;
          end else begin
            i_cnt <= i_cnt - 4'd1;
          end
        end
        default: i_state <= I_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- dbus
  typedef enum logic {D_IDLE, D_WAIT} d_state_t;

  d_state_t          d_state;
  logic [3:0]        d_cnt;
  logic              req;
  logic              cons_hit;
  logic              cons_full;
  logic              timing_done;
  logic              complete;
  logic [ADDR_W-1:0] d_idx;

  logic [7:0]        cons_mem [CONS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    cons_count;
  logic              push;
  logic              pop;

  // Requests seen while rst is high have no effect at all.
  assign req         = (iDbusWe | iDbusRead) & ~rst;
  assign cons_hit    = iDbusWe & iDbusByteEn[0] & (iDbusAddr == CONSOLE_ADDR);
  assign timing_done = (DWAIT == 0) ? 1'b1 : ((d_state == D_WAIT) && (d_cnt == 4'd0));
  // A console push into a full FIFO is held off until a pop frees a slot.
  assign complete    = req & timing_done & ~(cons_hit & cons_full);
  assign oDbusWait   = req & ~complete;
  assign d_idx       = iDbusAddr[ADDR_W+1:2];
  assign oDbusData   = (complete & ~iDbusWe) ? dmem[d_idx] : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state <= D_IDLE;
      d_cnt   <= 4'd0;
    end else begin
      case (d_state)
        D_IDLE: begin
          if (req && (DWAIT != 0)) begin
            d_cnt   <= 4'(DWAIT - 1);
            d_state <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (!req)
            d_state <= D_IDLE;       // abandoned request, no side effect
          else if (d_cnt != 4'd0)
            d_cnt <= d_cnt - 4'd1;
          else if (complete)
            d_state <= D_IDLE;       // a still-high req starts a new access
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (complete && iDbusWe && !cons_hit) begin
      case (iDbusByteEn)
        4'h1: dmem[d_idx][8*iDbusAddr[1:0] +: 8] <= iDbusData[7:0];
        4'h3: if (!iDbusAddr[0]) dmem[d_idx][16*iDbusAddr[1] +: 16] <= iDbusData[15:0];
        4'hF: dmem[d_idx] <= iDbusData;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------- console
  assign cons_full  = (cons_count == (PTR_W+1)'(CONS_DEPTH));
  assign oConsValid = (cons_count != '0);
  assign oConsData  = cons_mem[rd_ptr];
  assign push       = complete & cons_hit;
  assign pop        = oConsValid & iConsReady;

  always_ff @(posedge clk) begin
    if (push) cons_mem[wr_ptr] <= iDbusData[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cons_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cons_count <= cons_count + 1'b1;
        2'b01:   cons_count <= cons_count - 1'b1;
        default: cons_count <= cons_count;
      endcase
    end
  end

endmodule

// File: tb/tb_risac_mem_model.sv
// tb/tb_risac_mem_model.sv - directed self-checking bench for risac_mem_model
module tb_risac_mem_model;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iIbusAddr;
  logic [31:0] oIbusData;
  logic [31:0] oIbusIAddr;
  logic        oIbusWait;
  logic [31:0] iDbusAddr;
  logic        iDbusWe;
  logic        iDbusRead;
  logic [31:0] iDbusData;
  logic [3:0]  iDbusByteEn;
  logic [31:0] oDbusData;
  logic        oDbusWait;
  logic        oConsValid;
  logic [7:0]  oConsData;
  logic        iConsReady;

  localparam logic [31:0] CONS = 32'h8000_0000;

  int errors = 0;
  int checks = 0;

  risac_mem_model #(
    .ADDR_W(8), .IWAIT(2), .DWAIT(3), .CONSOLE_ADDR(CONS), .CONS_DEPTH(4),
    .IMEM_INIT(""), .DMEM_INIT("")
  ) dut (
    .clk(clk), .rst(rst),
    .iIbusAddr(iIbusAddr), .oIbusData(oIbusData), .oIbusIAddr(oIbusIAddr), .oIbusWait(oIbusWait),
    .iDbusAddr(iDbusAddr), .iDbusWe(iDbusWe), .iDbusRead(iDbusRead), .iDbusData(iDbusData),
    .iDbusByteEn(iDbusByteEn), .oDbusData(oDbusData), .oDbusWait(oDbusWait),
    .oConsValid(oConsValid), .oConsData(oConsData), .iConsReady(iConsReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request at a negedge, holds it until oDbusWait drops, then
  // releases the bus at the following negedge (after the commit edge).
  task automatic dbus(input logic we, input logic rd, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] be,
                      output int waits, output logic [31:0] rdata);
    logic done;
    done  = 1'b0;
    waits = 0;
    rdata = 32'd0;
    iDbusWe = we; iDbusRead = rd; iDbusAddr = addr; iDbusData = data; iDbusByteEn = be;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!oDbusWait) begin
        rdata = oDbusData;
        done  = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (!done) check("dbus_timeout", 32'd0, 32'd1);
    @(negedge clk);
    iDbusWe = 1'b0; iDbusRead = 1'b0;
  endtask

  task automatic ibus_settle(output int waits);
    waits = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!oIbusWait) break;
      waits++;
      @(negedge clk);
    end
    if (oIbusWait) check("ibus_timeout", 32'd0, 32'd1);
  endtask

  int          w;
  logic [31:0] rd;
  logic        stalled;

  initial begin
    dut.imem[0] = 32'hA0A0_0000;
    dut.imem[1] = 32'h1111_0001;
    dut.imem[2] = 32'h2222_0002;
    rst = 1'b1; iIbusAddr = 32'd0; iDbusAddr = 32'd0; iDbusWe = 1'b0; iDbusRead = 1'b0;
    iDbusData = 32'd0; iDbusByteEn = 4'h0; iConsReady = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_iaddr", oIbusIAddr, 32'hFFFF_FFFF);
    check("rst_idata", oIbusData, 32'd0);
    check("rst_ddata", oDbusData, 32'd0);
    check("rst_dwait", {31'd0, oDbusWait}, 32'd0);
    check("rst_cvalid", {31'd0, oConsValid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("fetch0_addr", oIbusIAddr, 32'd0);
    check("fetch0_data", oIbusData, 32'hA0A0_0000);

    // Fetch with IWAIT=2
    @(negedge clk);
    iIbusAddr = 32'd4;
    ibus_settle(w);
    check("fetch4_waits", w, 32'd3);
    check("fetch4_data", oIbusData, 32'h1111_0001);
    check("fetch4_addr", oIbusIAddr, 32'd4);

    // Word store/load with DWAIT=3
    @(negedge clk);
    dbus(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, w, rd);
    check("sw_waits", w, 32'd3);
    dbus(1'b0, 1'b1, 32'h10, 32'd0, 4'hF, w, rd);
    check("lw_waits", w, 32'd3);
    check("lw_data", rd, 32'hDEAD_BEEF);

    // Byte and half lanes
    dbus(1'b1, 1'b0, 32'h14, 32'h1122_3344, 4'hF, w, rd);
    dbus(1'b1, 1'b0, 32'h17, 32'h0000_00AA, 4'h1, w, rd);
    dbus(1'b1, 1'b0, 32'h14, 32'h0000_BBCC, 4'h3, w, rd);
    dbus(1'b0, 1'b1, 32'h14, 32'd0, 4'hF, w, rd);
    check("sb_sh_merge", rd, 32'hAA22_BBCC);
    dbus(1'b1, 1'b0, 32'h15, 32'h0000_7777, 4'h3, w, rd);
    dbus(1'b0, 1'b1, 32'h14, 32'd0, 4'hF, w, rd);
    check("sh_misaligned", rd, 32'hAA22_BBCC);
    dbus(1'b1, 1'b0, 32'h14, 32'hFFFF_FFFF, 4'h2, w, rd);
    check("bad_be_waits", w, 32'd3);
    dbus(1'b0, 1'b1, 32'h14, 32'd0, 4'hF, w, rd);
    check("bad_be_nowrite", rd, 32'hAA22_BBCC);

    // Address wrap
    dbus(1'b1, 1'b0, 32'h400, 32'h0000_0055, 4'hF, w, rd);
    dbus(1'b0, 1'b1, 32'h0, 32'd0, 4'hF, w, rd);
    check("wrap_read", rd, 32'h0000_0055);

    // Aborted write
    dbus(1'b1, 1'b0, 32'h20, 32'h1234_5678, 4'hF, w, rd);
    iDbusWe = 1'b1; iDbusAddr = 32'h20; iDbusData = 32'h0000_0099; iDbusByteEn = 4'hF;
    #1;
    check("abort_wait", {31'd0, oDbusWait}, 32'd1);
    @(negedge clk);
    iDbusWe = 1'b0;
    @(negedge clk);
    dbus(1'b0, 1'b1, 32'h20, 32'd0, 4'hF, w, rd);
    check("abort_nowrite", rd, 32'h1234_5678);

    // Console FIFO, depth 4, backpressure on the fifth push
    for (int k = 0; k < 4; k++) dbus(1'b1, 1'b0, CONS, 32'h41 + k, 4'h1, w, rd);
    #1;
    check("cons_valid", {31'd0, oConsValid}, 32'd1);
    check("cons_head", {24'd0, oConsData}, 32'h41);
    iDbusWe = 1'b1; iDbusAddr = CONS; iDbusData = 32'h45; iDbusByteEn = 4'h1;
    stalled = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (!oDbusWait) stalled = 1'b0;
      @(negedge clk);
    end
    check("cons_stall", {31'd0, stalled}, 32'd1);
    iConsReady = 1'b1;
    #1;
    check("pop_byte0", {24'd0, oConsData}, 32'h41);
    check("stall_during_pop", {31'd0, oDbusWait}, 32'd1);
    @(negedge clk);
    iConsReady = 1'b0;
    #1;
    check("stall_release", {31'd0, oDbusWait}, 32'd0);
    @(negedge clk);
    iDbusWe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("pop_valid", {31'd0, oConsValid}, 32'd1);
      check("pop_byte", {24'd0, oConsData}, 32'h42 + k);
      iConsReady = 1'b1;
      @(negedge clk);
      iConsReady = 1'b0;
    end
    #1;
    check("cons_empty", {31'd0, oConsValid}, 32'd0);

    // Reset during I_WAIT, with a byte left in the console FIFO
    @(negedge clk);
    dbus(1'b1, 1'b0, CONS, 32'h5A, 4'h1, w, rd);
    iIbusAddr = 32'd8;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_iaddr", oIbusIAddr, 32'hFFFF_FFFF);
    check("rst_mid_idata", oIbusData, 32'd0);
    check("rst_flush", {31'd0, oConsValid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    ibus_settle(w);
    check("fetch8_addr", oIbusIAddr, 32'd8);
    check("fetch8_data", oIbusData, 32'h2222_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
